// File: rtl/cave_pkg.sv
// Shared types and constants for the cave-flyer game blocks.
// The optional pause feature is enabled by defining CAVE_PAUSE_EN.
package cave_pkg;

  localparam int SCORE_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    CRASH  = 3'd4,
    OVER   = 3'd5
  } game_state_t;

  // RGB colour codes shared with the drawing blocks
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  // Tick period for a level; the difference is signed so an underflow also clamps to the floor
  function automatic logic [31:0] calc_period(input logic [31:0] base,
                                              input logic [31:0] min_d,
                                              input logic [31:0] weight,
                                              input logic [15:0] level);
    logic [32:0]        prod;
    logic signed [32:0] diff;
    prod = {1'b0, weight} * {17'd0, level};
    diff = $signed({1'b0, base}) - $signed(prod);
    if (diff < $signed({1'b0, min_d})) return min_d;
    return diff[31:0];
  endfunction

endpackage

// File: rtl/cave_tick_gen.sv
// Programmable-period strobe: counts 0..period-1 while enabled and pulses on the wrap cycle.
// A new period is latched only at a clear or a wrap, so a running count is never cut short.
module cave_tick_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [31:0] i_period,
  output logic        o_tick
);

  logic [31:0] r_cnt;
  logic [31:0] r_cur;
  logic        w_wrap;

  assign w_wrap = (r_cnt >= r_cur - 32'd1);
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= 32'd0;
      r_cur <= i_period;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cnt <= 32'd0;
        r_cur <= i_period;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/cave_game_ctrl.sv
// Cave-flyer game sequencer: FSM, scroll-rate scheduling, score and high score.
// Defining CAVE_PAUSE_EN adds the pause input and the PAUSED state.
module cave_game_ctrl
  import cave_pkg::*;
#(
  parameter int unsigned BASE_DELAY   = 4000000,
  parameter int unsigned MIN_DELAY    = 500000,
  parameter int unsigned WEIGHT       = 50000,
  parameter int unsigned LEVEL_SHIFT  = 4,
  parameter int unsigned TICKS_PER_PT = 8,
  parameter int unsigned CRASH_FRAMES = 60,
  parameter int unsigned SCORE_MAX    = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               collide,
  input  logic               frame_start,
`ifdef CAVE_PAUSE_EN
  input  logic               pause,
`endif
  output logic               bound_clr,
  output logic               shift_tick,
  output logic [2:0]         state_o,
  output logic               gameover,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_READY  = READY;
  localparam logic [2:0] S_PLAY   = PLAY;
  localparam logic [2:0] S_CRASH  = CRASH;
  localparam logic [2:0] S_OVER   = OVER;
`ifdef CAVE_PAUSE_EN
  localparam logic [2:0] S_PAUSED = PAUSED;
`endif

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic               r_start_q;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_hi;
  logic [SCORE_W-1:0] w_score_next;
  logic [15:0]        r_pt_cnt;
  logic [15:0]        r_frames;
  logic [31:0]        r_period;
  logic [31:0]        w_tick_period;
  logic               w_start_rise;
  logic               w_run;
  logic               w_tick;
  logic               w_point;
  logic               w_crash_entry;

  // History resets high so a button held through reset does not start a game
  assign w_start_rise = start & ~r_start_q;

`ifdef CAVE_PAUSE_EN
  assign w_run = (r_state == S_PLAY) && !pause;
`else
  assign w_run = (r_state == S_PLAY);
`endif

  // READY reloads the base period directly since r_period only settles one cycle later
  assign w_tick_period = (r_state == S_READY) ? 32'(BASE_DELAY) : r_period;

  cave_tick_gen u_tick (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_run),
    .i_clr    (r_state == S_READY),
    .i_period (w_tick_period),
    .o_tick   (w_tick)
  );

  assign w_point       = w_tick && (r_pt_cnt == 16'(TICKS_PER_PT - 1));
  assign w_crash_entry = (r_state == S_PLAY) && (w_state_next == S_CRASH);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_rise) w_state_next = S_READY;
      S_READY:  w_state_next = S_PLAY;
      S_PLAY: begin
`ifdef CAVE_PAUSE_EN
        if (pause)        w_state_next = S_PAUSED;
        else if (collide) w_state_next = S_CRASH;
`else
        if (collide)      w_state_next = S_CRASH;
`endif
      end
`ifdef CAVE_PAUSE_EN
      S_PAUSED: if (!pause) w_state_next = S_PLAY;
`endif
      S_CRASH:  if (frame_start && (r_frames == 16'(CRASH_FRAMES - 1))) w_state_next = S_OVER;
      S_OVER:   if (w_start_rise) w_state_next = S_READY;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // A point earned on the collision cycle still counts, including toward the high score
  always_comb begin
    w_score_next = r_score;
    if (r_state == S_READY)
      w_score_next = '0;
    else if (w_point && (r_score < SCORE_W'(SCORE_MAX)))
      w_score_next = r_score + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b1;
      r_score   <= '0;
      r_hi      <= '0;
      r_pt_cnt  <= '0;
      r_frames  <= '0;
      r_period  <= 32'(BASE_DELAY);
    end else begin
      r_state   <= w_state_next;
      r_start_q <= start;
      r_score   <= w_score_next;
      if (w_crash_entry && (w_score_next > r_hi))
        r_hi <= w_score_next;
      if (r_state == S_READY)
        r_pt_cnt <= '0;
      else if (w_tick)
        r_pt_cnt <= w_point ? 16'd0 : r_pt_cnt + 16'd1;
      if (r_state != S_CRASH)
        r_frames <= '0;
      else if (frame_start)
        r_frames <= r_frames + 16'd1;
      if (r_state == S_READY)
        r_period <= 32'(BASE_DELAY);
      else
        r_period <= calc_period(32'(BASE_DELAY), 32'(MIN_DELAY), 32'(WEIGHT),
                                r_score >> LEVEL_SHIFT);
    end
  end

  assign bound_clr  = (r_state == S_READY);
  assign shift_tick = w_tick;
  assign state_o    = r_state;
  assign gameover   = (r_state == S_CRASH) || (r_state == S_OVER);
  assign score      = r_score;
  assign hi_score   = r_hi;

endmodule

// File: tb/tb_cave_game_ctrl.sv
// Directed bench for cave_game_ctrl with small delays; SCORE_MAX is lowered to 12 so
// saturation is reached in a few hundred cycles. Pause steps build only with CAVE_PAUSE_EN.
module tb_cave_game_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        collide;
  logic        frame_start;
`ifdef CAVE_PAUSE_EN
  logic        pause;
`endif
  logic        bound_clr;
  logic        shift_tick;
  logic [2:0]  state_o;
  logic        gameover;
  logic [15:0] score;
  logic [15:0] hi_score;

  int vec  = 0;
  int errs = 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READY  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_CRASH  = 3'd4;
  localparam logic [2:0] ST_OVER   = 3'd5;

  always #5 clk = ~clk;

  cave_game_ctrl #(
    .BASE_DELAY   (20),
    .MIN_DELAY    (4),
    .WEIGHT       (4),
    .LEVEL_SHIFT  (1),
    .TICKS_PER_PT (2),
    .CRASH_FRAMES (3),
    .SCORE_MAX    (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .collide     (collide),
    .frame_start (frame_start),
`ifdef CAVE_PAUSE_EN
    .pause       (pause),
`endif
    .bound_clr   (bound_clr),
    .shift_tick  (shift_tick),
    .state_o     (state_o),
    .gameover    (gameover),
    .score       (score),
    .hi_score    (hi_score)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Cycles between ticks: 19 from PLAY entry, then 20,16,12,8 for four ticks each, floor 4
  function automatic int exp_iv(input int k);
    if (k == 1)  return 19;
    if (k <= 5)  return 20;
    if (k <= 9)  return 16;
    if (k <= 13) return 12;
    if (k <= 17) return 8;
    return 4;
  endfunction

  // Score visible on the cycle of tick k (a point lands after every 2nd tick)
  function automatic int exp_score(input int k);
    int s;
    s = (k - 1) / 2;
    return (s > 12) ? 12 : s;
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!shift_tick && n < 64);
  endtask

  task automatic play_ticks(input int first, input int last);
    int n;
    for (int k = first; k <= last; k++) begin
      wait_tick(n);
      chk($sformatf("tick%0d_interval", k), n, exp_iv(k));
      chk($sformatf("tick%0d_score", k), score, exp_score(k));
    end
  endtask

  task automatic start_game();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("ready_state", state_o, ST_READY);
    chk("ready_bound_clr", bound_clr, 1);
    start = 1'b0;
    step();
    chk("play_state", state_o, ST_PLAY);
    chk("play_bound_clr", bound_clr, 0);
    chk("play_score_cleared", score, 0);
  endtask

  task automatic crash_to_over();
    for (int i = 1; i <= 3; i++) begin
      repeat (2) step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk($sformatf("frame%0d_state", i), state_o, (i < 3) ? ST_CRASH : ST_OVER);
      chk($sformatf("frame%0d_gameover", i), gameover, 1);
    end
  endtask

  initial begin
    int n;
    int ticks;
    reset = 1'b1;
    start = 1'b1;
    collide = 1'b0;
    frame_start = 1'b0;
`ifdef CAVE_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) step();
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_bound_clr", bound_clr, 0);
    chk("rst_shift_tick", shift_tick, 0);
    chk("rst_gameover", gameover, 0);
    chk("rst_score", score, 0);
    chk("rst_hi_score", hi_score, 0);
    reset = 1'b0;
    repeat (5) step();
    chk("held_start_idle", state_o, ST_IDLE);

    // Game 1: collide on the 10th tick, whose point is still awarded
    start_game();
    play_ticks(1, 10);
    collide = 1'b1;
    step();
    collide = 1'b0;
    chk("g1_crash_state", state_o, ST_CRASH);
    chk("g1_gameover", gameover, 1);
    chk("g1_score", score, 5);
    chk("g1_hi_score", hi_score, 5);
    ticks = 0;
    repeat (30) begin
      if (shift_tick) ticks++;
      step();
    end
    chk("g1_crash_no_ticks", ticks, 0);
    crash_to_over();

    // Game 2: lower score must not replace the high score
    start_game();
    play_ticks(1, 6);
    step();
    chk("g2_score_before_crash", score, 3);
    collide = 1'b1;
    step();
    collide = 1'b0;
    chk("g2_crash_state", state_o, ST_CRASH);
    chk("g2_score", score, 3);
    chk("g2_hi_score_kept", hi_score, 5);
    crash_to_over();

    // Game 3: collide sampled in the very first PLAY cycle
    start_game();
    collide = 1'b1;
    step();
    collide = 1'b0;
    chk("g3_first_cycle_crash", state_o, ST_CRASH);
    chk("g3_score", score, 0);
    chk("g3_hi_score_kept", hi_score, 5);
    crash_to_over();

    // Game 4: period clamp, score saturation, reset in CRASH
    start_game();
`ifdef CAVE_PAUSE_EN
    play_ticks(1, 2);
    repeat (5) step();
    pause = 1'b1;
    step();
    chk("pause_state", state_o, ST_PAUSED);
    collide = 1'b1;
    ticks = 0;
    repeat (48) begin
      step();
      if (shift_tick) ticks++;
    end
    collide = 1'b0;
    step();
    chk("pause_no_ticks", ticks, 0);
    chk("pause_collide_ignored", state_o, ST_PAUSED);
    pause = 1'b0;
    wait_tick(n);
    chk("pause_resume_interval", n, 16);
    chk("pause_resume_score", score, 1);
    play_ticks(4, 30);
`else
    play_ticks(1, 30);
`endif
    step();
    chk("g4_score_saturated", score, 12);
    collide = 1'b1;
    step();
    collide = 1'b0;
    chk("g4_crash_state", state_o, ST_CRASH);
    chk("g4_hi_score", hi_score, 12);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("g4_still_crash", state_o, ST_CRASH);
    reset = 1'b1;
    step();
    chk("midcrash_rst_state", state_o, ST_IDLE);
    chk("midcrash_rst_gameover", gameover, 0);
    chk("midcrash_rst_score", score, 0);
    chk("midcrash_rst_hi_score", hi_score, 0);
    chk("midcrash_rst_bound_clr", bound_clr, 0);
    chk("midcrash_rst_shift_tick", shift_tick, 0);
    reset = 1'b0;
    repeat (3) step();
    chk("post_rst_idle", state_o, ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
